dff_pipe: RTL

Parametrised register pipeline that generalises the single D flip-flop into a WIDTH-bit, DEPTH-stage delay line with per-stage valid tracking, valid/ready flow control, bubble collapsing, flush, and an occupancy count. It sits between a producer and a consumer that need a fixed registered delay, tolerate back-pressure, and must be drained or cleared on demand.

---
 rtl/dff_pipe.sv | 86 ++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// Parametrised WIDTH x DEPTH register pipeline with per-stage valid bits,
// valid/ready flow control, bubble collapsing, flush and occupancy count.
module dff_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             q,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            adv;
    logic [CW-1:0]               count_q, count_d;
    logic                        accept;

    // Advance chain: a stage moves whenever any stage at or past it is empty,
    // or the consumer is draining the last stage.
    always_comb begin
        logic chain;
        adv          = '0;
        chain        = out_ready | ~valid_q[DEPTH-1];
        adv[DEPTH-1] = chain;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            chain  = ~valid_q[k] | chain;
            adv[k] = chain;
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign accept   = in_valid & in_ready;

    // Next-state: shift advancing stages, load S0, recompute occupancy.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = '0;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (adv[k]) begin
                    data_d[k]  = data_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end
            if (adv[0]) begin
                valid_d[0] = accept;
                if (accept) begin
                    data_d[0] = din;
                end
            end
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            count_d = count_d + CW'(valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= {DEPTH{RST_VAL}};
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign q         = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign count     = count_q;

endmodule
